// File: rtl/dispensador_billetes.sv
// Cash-dispense sequencer: greedy bill plan against per-denomination inventory,
// then one bill at a time over a REQ/ACK handshake with a timeout watchdog.
module dispensador_billetes #(
    parameter int unsigned DEN0        = 20000,
    parameter int unsigned DEN1        = 10000,
    parameter int unsigned DEN2        = 5000,
    parameter int unsigned DEN3        = 1000,
    parameter logic [7:0]  INV_INICIAL = 8'd10,
    parameter int unsigned TIMEOUT     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        entregar_dinero_i,
    input  logic [31:0] monto_i,
    input  logic        bill_ack_i,
    output logic        bill_req_o,
    output logic [1:0]  bill_denom_o,
    output logic        ocupado_o,
    output logic        dispensa_ok_o,
    output logic        monto_invalido_o,
    output logic        falla_mecanica_o,
    output logic [31:0] inventario_o
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, PLAN, DISP_REQ, WAIT_ACK, GAP, DONE, INVAL, FAULT
    } state_t;

    function automatic logic [31:0] den_of(input logic [1:0] i);
        logic [31:0] d;
        case (i)
            2'd0:    d = 32'(DEN0);
            2'd1:    d = 32'(DEN1);
            2'd2:    d = 32'(DEN2);
            2'd3:    d = 32'(DEN3);
            default: d = 32'(DEN3);
        endcase
        return d;
    endfunction

    state_t          state_q, state_d;
    logic [31:0]     rem_q, rem_d;
    logic [1:0]      idx_q, idx_d;
    logic [3:0][7:0] plan_q, plan_d;
    logic [3:0][7:0] inv_q, inv_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            pend_any;
    logic [1:0]      pend_idx;
    logic            bill_req_q, ocupado_q, dispensa_ok_q, monto_invalido_q, falla_mecanica_q;
    logic [1:0]      bill_denom_q;

    // Lowest denomination index that still has bills left to issue.
    always_comb begin
        pend_any = 1'b0;
        pend_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (plan_q[i] != 8'd0) begin
                pend_any = 1'b1;
                pend_idx = 2'(i);
            end else begin
                pend_any = pend_any;
            end
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        idx_d   = idx_q;
        plan_d  = plan_q;
        inv_d   = inv_q;
        tmo_d   = tmo_q;
        case (state_q)
            IDLE: begin
                if (entregar_dinero_i) begin
                    if (monto_i == 32'd0) begin
                        state_d = INVAL;
                    end else begin
                        rem_d   = monto_i;
                        idx_d   = 2'd0;
                        plan_d  = '0;
                        state_d = PLAN;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            PLAN: begin
                // Compare before subtract keeps rem from underflowing.
                if (rem_q >= den_of(idx_q) && plan_q[idx_q] < inv_q[idx_q]) begin
                    rem_d          = rem_q - den_of(idx_q);
                    plan_d[idx_q]  = plan_q[idx_q] + 8'd1;
                end else if (idx_q != 2'd3) begin
                    idx_d = idx_q + 2'd1;
                end else if (rem_q == 32'd0) begin
                    idx_d   = 2'd0;
                    state_d = DISP_REQ;
                end else begin
                    state_d = INVAL;
                end
            end
            DISP_REQ: begin
                if (pend_any) begin
                    idx_d   = pend_idx;
                    tmo_d   = '0;
                    state_d = WAIT_ACK;
                end else begin
                    state_d = DONE;
                end
            end
            WAIT_ACK: begin
                if (bill_ack_i) begin
                    inv_d[idx_q]  = inv_q[idx_q] - 8'd1;
                    plan_d[idx_q] = plan_q[idx_q] - 8'd1;
                    state_d       = GAP;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = FAULT;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            GAP:     state_d = DISP_REQ;
            DONE:    state_d = IDLE;
            INVAL:   state_d = IDLE;
            FAULT:   state_d = FAULT;
            default: state_d = IDLE;
        endcase
    end

    // State, datapath and output registers; outputs follow the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            rem_q            <= 32'd0;
            idx_q            <= 2'd0;
            plan_q           <= '0;
            inv_q            <= {4{INV_INICIAL}};
            tmo_q            <= '0;
            bill_req_q       <= 1'b0;
            bill_denom_q     <= 2'd0;
            ocupado_q        <= 1'b0;
            dispensa_ok_q    <= 1'b0;
            monto_invalido_q <= 1'b0;
            falla_mecanica_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            rem_q            <= rem_d;
            idx_q            <= idx_d;
            plan_q           <= plan_d;
            inv_q            <= inv_d;
            tmo_q            <= tmo_d;
            bill_req_q       <= (state_d == WAIT_ACK);
            bill_denom_q     <= (state_d == WAIT_ACK) ? idx_d : 2'd0;
            ocupado_q        <= (state_d != IDLE);
            dispensa_ok_q    <= (state_d == DONE);
            monto_invalido_q <= (state_d == INVAL);
            falla_mecanica_q <= (state_d == FAULT);
        end
    end

    assign bill_req_o       = bill_req_q;
    assign bill_denom_o     = bill_denom_q;
    assign ocupado_o        = ocupado_q;
    assign dispensa_ok_o    = dispensa_ok_q;
    assign monto_invalido_o = monto_invalido_q;
    assign falla_mecanica_o = falla_mecanica_q;
    assign inventario_o     = {inv_q[0], inv_q[1], inv_q[2], inv_q[3]};

endmodule

// File: tb/tb_dispensador_billetes.sv
// Directed bench for dispensador_billetes: hand-computed bill sequences,
// inventory values, invalid amounts, timeout fault and async reset.
module tb_dispensador_billetes;

    logic        clk = 1'b0;
    logic        rst;
    logic        entregar_dinero_i;
    logic [31:0] monto_i;
    logic        bill_ack_i;
    logic        bill_req_o;
    logic [1:0]  bill_denom_o;
    logic        ocupado_o;
    logic        dispensa_ok_o;
    logic        monto_invalido_o;
    logic        falla_mecanica_o;
    logic [31:0] inventario_o;

    int checks = 0;
    int errors = 0;

    dispensador_billetes dut (
        .clk               (clk),
        .rst               (rst),
        .entregar_dinero_i (entregar_dinero_i),
        .monto_i           (monto_i),
        .bill_ack_i        (bill_ack_i),
        .bill_req_o        (bill_req_o),
        .bill_denom_o      (bill_denom_o),
        .ocupado_o         (ocupado_o),
        .dispensa_ok_o     (dispensa_ok_o),
        .monto_invalido_o  (monto_invalido_o),
        .falla_mecanica_o  (falla_mecanica_o),
        .inventario_o      (inventario_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic start(input logic [31:0] m);
        @(negedge clk);
        entregar_dinero_i = 1'b1;
        monto_i           = m;
        @(negedge clk);
        entregar_dinero_i = 1'b0;
    endtask

    // Wait for REQ, check its denomination, ACK so it is sampled k edges after REQ rose.
    task automatic serve_bill(input int k, input logic [1:0] denom, input string tag);
        logic seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (bill_req_o) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_req_seen"}, 32'(seen), 32'd1);
        chk({tag, "_denom"}, 32'(bill_denom_o), 32'(denom));
        for (int i = 1; i < k; i++) @(negedge clk);
        chk({tag, "_req_held"}, 32'(bill_req_o), 32'd1);
        bill_ack_i = 1'b1;
        @(negedge clk);
        bill_ack_i = 1'b0;
        chk({tag, "_req_drop"}, 32'(bill_req_o), 32'd0);
    endtask

    task automatic wait_ok(input string tag);
        logic seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (dispensa_ok_o) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_ok_seen"}, 32'(seen), 32'd1);
        @(negedge clk);
        chk({tag, "_ok_1cyc"}, 32'(dispensa_ok_o), 32'd0);
        chk({tag, "_idle"}, 32'(ocupado_o), 32'd0);
    endtask

    task automatic wait_inval(input string tag);
        logic seen     = 1'b0;
        logic req_seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (bill_req_o) req_seen = 1'b1;
            if (monto_invalido_o) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_inval_seen"}, 32'(seen), 32'd1);
        chk({tag, "_no_req"}, 32'(req_seen), 32'd0);
        @(negedge clk);
        chk({tag, "_inval_1cyc"}, 32'(monto_invalido_o), 32'd0);
    endtask

    initial begin
        int hi_cnt;
        logic extra_req;
        rst               = 1'b1;
        entregar_dinero_i = 1'b0;
        monto_i           = 32'd0;
        bill_ack_i        = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_req", 32'(bill_req_o), 32'd0);
        chk("rst_denom", 32'(bill_denom_o), 32'd0);
        chk("rst_busy", 32'(ocupado_o), 32'd0);
        chk("rst_ok", 32'(dispensa_ok_o), 32'd0);
        chk("rst_inval", 32'(monto_invalido_o), 32'd0);
        chk("rst_fault", 32'(falla_mecanica_o), 32'd0);
        chk("rst_inv", inventario_o, 32'h0A0A0A0A);
        rst = 1'b0;

        // 1) 36000 = 20000 + 10000 + 5000 + 1000
        start(32'd36000);
        chk("t1_busy", 32'(ocupado_o), 32'd1);
        serve_bill(2, 2'd0, "t1_b0");
        serve_bill(2, 2'd1, "t1_b1");
        serve_bill(2, 2'd2, "t1_b2");
        serve_bill(2, 2'd3, "t1_b3");
        wait_ok("t1");
        chk("t1_inv", inventario_o, 32'h09090909);

        // 2) unpayable amounts
        start(32'd1500);
        wait_inval("t2a");
        chk("t2a_inv", inventario_o, 32'h09090909);
        start(32'd0);
        wait_inval("t2b");
        chk("t2b_inv", inventario_o, 32'h09090909);

        // 3) drain denomination 0, then fall back to denomination 1
        pulse_rst();
        start(32'd200000);
        for (int b = 0; b < 10; b++) serve_bill(1, 2'd0, "t3a");
        wait_ok("t3a");
        chk("t3a_inv", inventario_o, 32'h000A0A0A);
        start(32'd60000);
        for (int b = 0; b < 6; b++) serve_bill(1, 2'd1, "t3b");
        wait_ok("t3b");
        chk("t3b_inv", inventario_o, 32'h00040A0A);

        // 4) no ACK: REQ held exactly 16 cycles, then sticky fault
        pulse_rst();
        start(32'd5000);
        for (int i = 0; i < 60; i++) begin
            if (bill_req_o) break;
            @(negedge clk);
        end
        hi_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (!bill_req_o) break;
            hi_cnt++;
            @(negedge clk);
        end
        chk("t4_req_cycles", 32'(hi_cnt), 32'd16);
        chk("t4_fault", 32'(falla_mecanica_o), 32'd1);
        chk("t4_busy", 32'(ocupado_o), 32'd1);
        start(32'd1000);
        extra_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bill_req_o) extra_req = 1'b1;
            @(negedge clk);
        end
        chk("t4_ignored_req", 32'(extra_req), 32'd0);
        chk("t4_fault_sticky", 32'(falla_mecanica_o), 32'd1);
        chk("t4_inv", inventario_o, 32'h0A0A0A0A);
        pulse_rst();
        chk("t4_rst_fault", 32'(falla_mecanica_o), 32'd0);
        chk("t4_rst_busy", 32'(ocupado_o), 32'd0);

        // 5) reset during WAIT_ACK of the second 20000 bill
        start(32'd40000);
        serve_bill(1, 2'd0, "t5_b0");
        for (int i = 0; i < 60; i++) begin
            if (bill_req_o) break;
            @(negedge clk);
        end
        chk("t5_req2", 32'(bill_req_o), 32'd1);
        chk("t5_inv_mid", inventario_o, 32'h090A0A0A);
        rst = 1'b1;
        #1;
        chk("t5_async_req", 32'(bill_req_o), 32'd0);
        chk("t5_async_busy", 32'(ocupado_o), 32'd0);
        chk("t5_async_inv", inventario_o, 32'h0A0A0A0A);
        @(negedge clk);
        rst = 1'b0;

        // 6) second start while busy is ignored
        start(32'd20000);
        entregar_dinero_i = 1'b1;
        monto_i           = 32'd1000;
        @(negedge clk);
        entregar_dinero_i = 1'b0;
        serve_bill(1, 2'd0, "t6_b0");
        wait_ok("t6");
        extra_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bill_req_o) extra_req = 1'b1;
            @(negedge clk);
        end
        chk("t6_no_extra", 32'(extra_req), 32'd0);
        chk("t6_inv", inventario_o, 32'h090A0A0A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
